// File: rtl/fetch_pc_gen_pkg.sv
// risXv_macro: definitions shared by the fetch PC generator slice.
//   pc_state_e      - PC generator FSM states
//   BOOT_PC_DEFAULT - boot PC used when BOOT_PC is not overridden
//   slot_count()    - number of 4-byte slots in a fetch block
package risXv_macro;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } pc_state_e;

  localparam logic [63:0] BOOT_PC_DEFAULT = 64'h0000_0000_8000_0000;

  function automatic int slot_count(input int fetch_bytes);
    return fetch_bytes / 4;
  endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// Fetch PC generator bus: redirect/stall inputs from the back end, the
// fetch handshake, and the generated fetch request.
//   master - the PC generator (drives o_pcGen_*)
//   slave  - the environment (drives i_*)
interface fetch_pc_gen_if #(
  parameter int XLEN         = 64,
  parameter int FETCH_BYTES  = 16,
  parameter int NUM_REDIRECT = 3,
  parameter int EPOCH_W      = 3
);

  logic                                 i_stall;
  logic [NUM_REDIRECT-1:0]              i_redirect_valid;
  logic [NUM_REDIRECT-1:0][XLEN-1:0]    i_redirect_pc;
  logic                                 i_fetch_ready;
  logic                                 o_pcGen_valid;
  logic [XLEN-1:0]                      o_pcGen_cPc;
  logic [XLEN-1:0]                      o_pcGen_npc;
  logic [FETCH_BYTES/4-1:0]             o_pcGen_mask;
  logic [EPOCH_W-1:0]                   o_pcGen_epoch;

  modport master (
    input  i_stall, i_redirect_valid, i_redirect_pc, i_fetch_ready,
    output o_pcGen_valid, o_pcGen_cPc, o_pcGen_npc, o_pcGen_mask, o_pcGen_epoch
  );

  modport slave (
    output i_stall, i_redirect_valid, i_redirect_pc, i_fetch_ready,
    input  o_pcGen_valid, o_pcGen_cPc, o_pcGen_npc, o_pcGen_mask, o_pcGen_epoch
  );

endinterface

// File: rtl/fetch_pc_gen_redirect_arb.sv
// redirect_arb: fixed-priority arbiter over the redirect channels.
// Channel 0 has the highest priority. The selected target comes out
// 4-byte aligned.
//   i_valid - per-channel redirect request
//   i_pc    - per-channel redirect target
//   o_any   - at least one channel requests
//   o_pc    - target of the winning channel, bits [1:0] cleared
module redirect_arb #(
  parameter int XLEN         = 64,
  parameter int NUM_REDIRECT = 3
) (
  input  logic [NUM_REDIRECT-1:0]           i_valid,
  input  logic [NUM_REDIRECT-1:0][XLEN-1:0] i_pc,
  output logic                              o_any,
  output logic [XLEN-1:0]                   o_pc
);

  logic [NUM_REDIRECT-1:0] grant;
  logic [XLEN-1:0]         sel;

  // Isolate the lowest set bit: one-hot grant to the lowest-index requester.
  assign grant = i_valid & (~i_valid + NUM_REDIRECT'(1));

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REDIRECT; i++) begin
      if (grant[i]) begin
        sel = sel | (i_pc[i] & ~XLEN'(3));
      end
    end
  end

  assign o_any = |i_valid;
  assign o_pc  = sel;

endmodule

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: generates the fetch block PC, slot mask and redirect epoch.
//   i_clk, i_rst      - clock, synchronous active-high reset
//   pc_if (master)    - i_stall, i_redirect_valid/pc, i_fetch_ready in;
//                       o_pcGen_valid/cPc/npc/mask/epoch out
//
// state   | meaning
// BOOT    | one idle cycle after reset, no request
// RUN     | presenting requests (unless stalled)
// PEND    | a redirect arrived under stall; target waits in pend_q
module fetch_pc_gen
  import risXv_macro::*;
#(
  parameter int              XLEN         = 64,
  parameter int              FETCH_BYTES  = 16,
  parameter int              NUM_REDIRECT = 3,
  parameter int              EPOCH_W      = 3,
  parameter logic [XLEN-1:0] BOOT_PC      = XLEN'(BOOT_PC_DEFAULT)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  fetch_pc_gen_if.master     pc_if
);

  localparam int              SLOTS = slot_count(FETCH_BYTES);
  localparam logic [XLEN-1:0] BLK   = XLEN'(FETCH_BYTES);

  pc_state_e          state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [XLEN-1:0]    pend_q, pend_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;

  logic               redir_any;
  logic [XLEN-1:0]    redir_tgt;
  logic               valid;
  logic [XLEN-1:0]    pc_adv;
  logic [XLEN-1:0]    slot_idx;
  logic [SLOTS-1:0]   mask;

  redirect_arb #(
    .XLEN         (XLEN),
    .NUM_REDIRECT (NUM_REDIRECT)
  ) u_redirect_arb (
    .i_valid (pc_if.i_redirect_valid),
    .i_pc    (pc_if.i_redirect_pc),
    .o_any   (redir_any),
    .o_pc    (redir_tgt)
  );

  // Gated by i_rst so the request is quiet even before the first reset edge.
  assign valid  = !i_rst && (state_q == ST_RUN) && !pc_if.i_stall;
  // Next aligned block; natural XLEN overflow gives the wrap to 0.
  assign pc_adv = (pc_q & ~(BLK - XLEN'(1))) + BLK;

  assign slot_idx = (pc_q & (BLK - XLEN'(1))) >> 2;

  always_comb begin
    mask = '0;
    for (int k = 0; k < SLOTS; k++) begin
      mask[k] = (XLEN'(k) >= slot_idx);
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    epoch_d = epoch_q + {{(EPOCH_W-1){1'b0}}, redir_any};
    if (i_rst) begin
      state_d = ST_BOOT;
      pc_d    = BOOT_PC;
      pend_d  = '0;
      epoch_d = '0;
    end else if (redir_any) begin
      if (pc_if.i_stall) begin
        pend_d  = redir_tgt;
        state_d = ST_PEND;
      end else begin
        pc_d    = redir_tgt;
        state_d = ST_RUN;
      end
    end else if ((state_q == ST_PEND) && !pc_if.i_stall) begin
      pc_d    = pend_q;
      state_d = ST_RUN;
    end else if (state_q == ST_BOOT) begin
      // BOOT lasts exactly one cycle, stalled or not.
      state_d = ST_RUN;
    end else if (valid && pc_if.i_fetch_ready) begin
      pc_d = pc_adv;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_BOOT;
      pc_q    <= BOOT_PC;
      pend_q  <= '0;
      epoch_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      epoch_q <= epoch_d;
    end
  end

  assign pc_if.o_pcGen_valid = valid;
  assign pc_if.o_pcGen_cPc   = pc_q;
  assign pc_if.o_pcGen_npc   = pc_d;
  assign pc_if.o_pcGen_mask  = mask;
  assign pc_if.o_pcGen_epoch = epoch_q;

endmodule

// File: doc/fetch_pc_gen.md
FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 64: PC width in bits.
REQ-002 SHALL have parameter FETCH_BYTES, default 16: fetch block size in bytes, a power of two from 4 to 64.
REQ-003 SHALL have parameter NUM_REDIRECT, default 3: number of redirect channels; index 0 has highest priority.
REQ-004 SHALL have parameter EPOCH_W, default 3: epoch counter width.
REQ-005 SHALL have parameter BOOT_PC, default the codebase boot PC: reset PC.
REQ-006 SHALL use one clock and a synchronous, active-high reset.
REQ-007 SHALL have port i_clk, input, 1 bit: clock.
REQ-008 SHALL have port i_rst, input, 1 bit: synchronous active-high reset.
REQ-009 SHALL have port i_stall, input, 1 bit: freezes the PC.
REQ-010 SHALL have port i_redirect_valid, input, NUM_REDIRECT bits: per-channel redirect request.
REQ-011 SHALL have port i_redirect_pc, input, NUM_REDIRECT x XLEN: per-channel target.
REQ-012 SHALL have port i_fetch_ready, input, 1 bit: fetch accepts the current request.
REQ-013 SHALL have port o_pcGen_valid, output, 1 bit: request valid.
REQ-014 SHALL have port o_pcGen_cPc, output, XLEN: current fetch PC.
REQ-015 SHALL have port o_pcGen_npc, output, XLEN: next-cycle PC register value (combinational).
REQ-016 SHALL have port o_pcGen_mask, output, FETCH_BYTES/4 bits: valid 4-byte slots.
REQ-017 SHALL have port o_pcGen_epoch, output, EPOCH_W bits: redirect generation tag.

Function
REQ-018 SHALL have states BOOT, RUN and PEND.
REQ-019 BOOT SHALL hold o_pcGen_valid=0 for exactly one cycle, then go to RUN.
REQ-020 SHALL drive o_pcGen_valid = (state==RUN) && !i_stall.
REQ-021 SHALL advance on an accepted request (valid && i_fetch_ready) to the next aligned block: (pc & ~(FETCH_BYTES-1)) + FETCH_BYTES, modulo 2^XLEN (wraps to 0).
REQ-022 SHALL select the lowest-index valid channel when redirects are simultaneous; bits [1:0] of the target are forced to 0.
REQ-023 In RUN without stall, a redirect SHALL load the PC next cycle and override any same-cycle handshake advance; the unaccepted request is dropped.
REQ-024 A redirect while i_stall=1 (RUN or PEND) SHALL be captured into a pending register and move the state to PEND; a later redirect overwrites the pending target.
REQ-025 PEND SHALL load the pending target into the PC on the first cycle with i_stall=0, then go to RUN; a redirect that cycle wins over the pending target.
REQ-026 i_stall=1 without a redirect SHALL hold PC, state and pending register unchanged.
REQ-027 The epoch SHALL increment, modulo 2^EPOCH_W, in every non-reset cycle with any i_redirect_valid bit set.
REQ-028 o_pcGen_mask bit k SHALL be 1 iff k >= cPc[log2(FETCH_BYTES)-1:2].
REQ-029 o_pcGen_npc SHALL equal the value the PC register takes at the next clock edge, under all priorities.
REQ-030 Next-state priority SHALL be: i_rst > redirect > pending apply > stall hold > handshake advance > hold.

Reset
REQ-031 On i_rst=1 at a clock edge: PC=BOOT_PC, state=BOOT, epoch=0, pending cleared.
REQ-032 Reset SHALL win over a same-cycle redirect, and that redirect SHALL NOT increment the epoch.
REQ-033 During reset o_pcGen_valid SHALL be 0 and o_pcGen_npc SHALL be BOOT_PC.

Structure
REQ-034 The state enum and the default boot PC SHALL live in the shared package risXv_macro.
REQ-035 SHALL have one sub-module, redirect_arb: a fixed-priority one-hot select and target mux over NUM_REDIRECT channels.

Verification (XLEN=32, FETCH_BYTES=16, BOOT_PC=0x8000_0000)
REQ-036 Release reset with ready=1 -> one cycle valid=0; then cPc 0x8000_0000, 0x8000_0010, 0x8000_0020; mask 4'b1111.
REQ-037 Redirect to 0x1000_0008 with no stall -> next cPc 0x1000_0008, mask 4'b1100, epoch +1; following cPc 0x1000_0010.
REQ-038 Channels 0 and 2 both valid (0x100, 0x200) -> cPc 0x100.
REQ-039 Stall 3 cycles with redirects 0x400 then 0x500 -> valid=0, cPc unchanged, epoch +2; on stall release cPc 0x500.
REQ-040 cPc=0xFFFF_FFF4, accepted -> next cPc 0x0000_0000; with i_rst and a redirect in the same cycle -> cPc 0x8000_0000, epoch 0.
